data_write_buffer: RTL and testbench

//  Posted-store buffer between the CPU data-memory port and the SRAM-like data port of the AXI bridge.

---
 rtl/data_write_buffer_pkg.sv | 25 ++
 rtl/data_write_buffer_fifo.sv | 88 ++++++++
 rtl/data_write_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_data_write_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_write_buffer_pkg.sv
// Shared types for the posted-store data write buffer: queued store entries and FSM state encodings.
package data_write_buffer_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic [1:0]  size;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
  } entry_t;

  typedef enum logic [1:0] {
    CpuIdle,
    CpuStoreAck,
    CpuLoadWait
  } cpu_state_t;

  typedef enum logic [2:0] {
    MemIdle,
    MemStoreAddress,
    MemStoreData,
    MemLoadAddress,
    MemLoadData
  } memory_state_t;

endpackage

// File: rtl/data_write_buffer_fifo.sv
// Circular store queue; exposes per-slot valid bits and word addresses for the load hazard check.
module data_write_buffer_fifo
  import data_write_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  entry_t                  push_entry_i,
  input  logic                    pop_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(Depth):0]  count_o,
  output entry_t                  head_o,
  output logic [Depth-1:0]        valid_o,
  output logic [Depth-1:0][29:0]  word_address_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0] CountOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [Depth-1:0] valid_q, valid_d;
  entry_t          entries_q [Depth];
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (push_ok) begin
      wr_ptr_d          = wr_ptr_q + PtrOne;
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d          = rd_ptr_q + PtrOne;
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload needs no reset: valid_q gates every use of a slot.
  always_ff @(posedge clock_i) begin
    if (push_ok) begin
      entries_q[wr_ptr_q] <= push_entry_i;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      word_address_o[i] = entries_q[i].address[31:2];
    end
  end

  assign count_o = count_q;
  assign head_o  = entries_q[rd_ptr_q];
  assign valid_o = valid_q;

endmodule

// File: rtl/data_write_buffer.sv
// Posted-store buffer between the CPU data port and the bridge data port. Stores are acked at
// once and drained in order; loads bypass queued stores unless a queued word address matches.
module data_write_buffer
  import data_write_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        cpu_request_i,
  input  logic        cpu_write_i,
  input  logic [1:0]  cpu_size_i,
  input  logic [31:0] cpu_address_i,
  input  logic [31:0] cpu_write_data_i,
  input  logic [3:0]  cpu_write_strobe_i,
  output logic [31:0] cpu_read_data_o,
  output logic        cpu_address_ready_o,
  output logic        cpu_data_ready_o,
  output logic        memory_request_o,
  output logic        memory_write_o,
  output logic [1:0]  memory_size_o,
  output logic [31:0] memory_address_o,
  output logic [31:0] memory_write_data_o,
  output logic [3:0]  memory_write_strobe_o,
  input  logic [31:0] memory_read_data_i,
  input  logic        memory_address_ready_i,
  input  logic        memory_data_ready_i,
  output logic        buffer_empty_o
);

  localparam int unsigned CountW = $clog2(Depth) + 1;

  cpu_state_t    cpu_state_q, cpu_state_d;
  memory_state_t mem_state_q, mem_state_d;

  logic        load_pending_q, load_pending_d;
  logic [31:0] load_address_q, load_address_d;
  logic [1:0]  load_size_q, load_size_d;
  logic        load_done_q, load_done_d;
  logic [31:0] read_data_q, read_data_d;

  logic        mem_write_q, mem_write_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_write_data_q, mem_write_data_d;
  logic [3:0]  mem_write_strobe_q, mem_write_strobe_d;

  logic                    fifo_full, fifo_empty, fifo_pop;
  logic [CountW-1:0]       fifo_count;
  entry_t                  fifo_head, push_entry;
  logic [Depth-1:0]        fifo_valid;
  logic [Depth-1:0][29:0]  fifo_word_address;

  logic hazard, store_hs, load_hs, load_go;

  assign push_entry = '{address:      cpu_address_i,
                        size:         cpu_size_i,
                        write_data:   cpu_write_data_i,
                        write_strobe: cpu_write_strobe_i};

  data_write_buffer_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .push_i         (store_hs),
    .push_entry_i   (push_entry),
    .pop_i          (fifo_pop),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .count_o        (fifo_count),
    .head_o         (fifo_head),
    .valid_o        (fifo_valid),
    .word_address_o (fifo_word_address)
  );

  // The draining head stays valid until its pop, so it still blocks a matching load.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (fifo_valid[i] && (fifo_word_address[i] == cpu_address_i[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cpu_state_q        <= CpuIdle;
      mem_state_q        <= MemIdle;
      load_pending_q     <= 1'b0;
      load_address_q     <= '0;
      load_size_q        <= '0;
      load_done_q        <= 1'b0;
      read_data_q        <= '0;
      mem_write_q        <= 1'b0;
      mem_size_q         <= '0;
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      mem_write_strobe_q <= '0;
    end else begin
      cpu_state_q        <= cpu_state_d;
      mem_state_q        <= mem_state_d;
      load_pending_q     <= load_pending_d;
      load_address_q     <= load_address_d;
      load_size_q        <= load_size_d;
      load_done_q        <= load_done_d;
      read_data_q        <= read_data_d;
      mem_write_q        <= mem_write_d;
      mem_size_q         <= mem_size_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      mem_write_strobe_q <= mem_write_strobe_d;
    end
  end

  // CPU-side outputs and handshakes.
  always_comb begin
    cpu_address_ready_o = 1'b0;
    cpu_data_ready_o    = 1'b0;
    unique case (cpu_state_q)
      CpuIdle:     cpu_address_ready_o = cpu_request_i && (cpu_write_i ? !fifo_full : !hazard);
      CpuStoreAck: cpu_data_ready_o = 1'b1;
      CpuLoadWait: cpu_data_ready_o = load_done_q;
      default:     cpu_data_ready_o = 1'b0;
    endcase
  end

  assign store_hs = cpu_address_ready_o && cpu_write_i;
  assign load_hs  = cpu_address_ready_o && !cpu_write_i;
  // A load handshaking this cycle can be issued directly if the memory side is idle.
  assign load_go  = load_pending_q || load_hs;

  // CPU-side next state and load capture.
  always_comb begin
    cpu_state_d    = cpu_state_q;
    load_pending_d = load_pending_q;
    load_address_d = load_address_q;
    load_size_d    = load_size_q;
    unique case (cpu_state_q)
      CpuIdle: begin
        if (store_hs) begin
          cpu_state_d = CpuStoreAck;
        end else if (load_hs) begin
          cpu_state_d    = CpuLoadWait;
          load_pending_d = 1'b1;
          load_address_d = cpu_address_i;
          load_size_d    = cpu_size_i;
        end
      end
      CpuStoreAck: cpu_state_d = CpuIdle;
      CpuLoadWait: if (load_done_q) cpu_state_d = CpuIdle;
      default:     cpu_state_d = CpuIdle;
    endcase
    if ((mem_state_q == MemIdle) && load_go) begin
      load_pending_d = 1'b0;
    end
  end

  // Memory-side next state; address-phase fields are loaded only when leaving MemIdle.
  always_comb begin
    mem_state_d        = mem_state_q;
    mem_write_d        = mem_write_q;
    mem_size_d         = mem_size_q;
    mem_address_d      = mem_address_q;
    mem_write_data_d   = mem_write_data_q;
    mem_write_strobe_d = mem_write_strobe_q;
    read_data_d        = read_data_q;
    load_done_d        = 1'b0;
    fifo_pop           = 1'b0;
    unique case (mem_state_q)
      MemIdle: begin
        if (load_go) begin
          mem_state_d        = MemLoadAddress;
          mem_write_d        = 1'b0;
          mem_size_d         = load_hs ? cpu_size_i : load_size_q;
          mem_address_d      = load_hs ? cpu_address_i : load_address_q;
          mem_write_data_d   = '0;
          mem_write_strobe_d = '0;
        end else if (!fifo_empty) begin
          mem_state_d        = MemStoreAddress;
          mem_write_d        = 1'b1;
          mem_size_d         = fifo_head.size;
          mem_address_d      = fifo_head.address;
          mem_write_data_d   = fifo_head.write_data;
          mem_write_strobe_d = fifo_head.write_strobe;
        end
      end
      MemStoreAddress: if (memory_address_ready_i) mem_state_d = MemStoreData;
      MemStoreData: begin
        if (memory_data_ready_i) begin
          fifo_pop    = 1'b1;
          mem_state_d = MemIdle;
        end
      end
      MemLoadAddress: if (memory_address_ready_i) mem_state_d = MemLoadData;
      MemLoadData: begin
        if (memory_data_ready_i) begin
          read_data_d = memory_read_data_i;
          load_done_d = 1'b1;
          mem_state_d = MemIdle;
        end
      end
      default: mem_state_d = MemIdle;
    endcase
  end

  // Memory-side outputs.
  always_comb begin
    memory_request_o = (mem_state_q == MemStoreAddress) || (mem_state_q == MemLoadAddress);
    buffer_empty_o   = (fifo_count == '0) &&
                       !((mem_state_q == MemStoreAddress) || (mem_state_q == MemStoreData));
  end

  assign memory_write_o        = mem_write_q;
  assign memory_size_o         = mem_size_q;
  assign memory_address_o      = mem_address_q;
  assign memory_write_data_o   = mem_write_data_q;
  assign memory_write_strobe_o = mem_write_strobe_q;
  assign cpu_read_data_o       = read_data_q;

endmodule

// File: tb/tb_data_write_buffer.sv
// Directed bench for data_write_buffer with a small SRAM-like slave on the memory port.
module tb_data_write_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_request = 1'b0, cpu_write = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic [31:0] cpu_address = 32'h0, cpu_write_data = 32'h0;
  logic [3:0]  cpu_write_strobe = 4'h0;
  logic [31:0] cpu_read_data;
  logic        cpu_address_ready, cpu_data_ready;
  logic        memory_request, memory_write;
  logic [1:0]  memory_size;
  logic [31:0] memory_address, memory_write_data;
  logic [3:0]  memory_write_strobe;
  logic [31:0] memory_read_data = 32'h0;
  logic        memory_address_ready = 1'b0, memory_data_ready = 1'b0;
  logic        buffer_empty;

  int checks = 0;
  int passed = 0;

  int          slave_lat = 0;
  bit          slave_hold = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  bit          hs_next = 1'b0;
  int          wait_cnt = 0;
  bit          log_write[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always #5 clock = ~clock;

  data_write_buffer #(
    .Depth (4)
  ) dut (
    .clock_i               (clock),
    .reset_i               (reset),
    .cpu_request_i         (cpu_request),
    .cpu_write_i           (cpu_write),
    .cpu_size_i            (cpu_size),
    .cpu_address_i         (cpu_address),
    .cpu_write_data_i      (cpu_write_data),
    .cpu_write_strobe_i    (cpu_write_strobe),
    .cpu_read_data_o       (cpu_read_data),
    .cpu_address_ready_o   (cpu_address_ready),
    .cpu_data_ready_o      (cpu_data_ready),
    .memory_request_o      (memory_request),
    .memory_write_o        (memory_write),
    .memory_size_o         (memory_size),
    .memory_address_o      (memory_address),
    .memory_write_data_o   (memory_write_data),
    .memory_write_strobe_o (memory_write_strobe),
    .memory_read_data_i    (memory_read_data),
    .memory_address_ready_i(memory_address_ready),
    .memory_data_ready_i   (memory_data_ready),
    .buffer_empty_o        (buffer_empty)
  );

  // Slave: address_ready after slave_lat request cycles, data_ready one cycle after handshake.
  initial begin
    forever begin
      @(negedge clock);
      memory_data_ready = hs_next;
      memory_read_data  = hs_next ? slave_rdata : 32'h0;
      hs_next = 1'b0;
      if (memory_request && !reset && !slave_hold && wait_cnt >= slave_lat) begin
        memory_address_ready = 1'b1;
        hs_next  = 1'b1;
        wait_cnt = 0;
        log_write.push_back(memory_write);
        log_addr.push_back(memory_address);
        log_data.push_back(memory_write_data);
      end else begin
        memory_address_ready = 1'b0;
        if (memory_request) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_log();
    log_write.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, output int waits,
                           output logic ack);
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = 1'b1; cpu_size = 2'd2;
    cpu_address = a; cpu_write_data = d; cpu_write_strobe = 4'hf;
    #1;
    waits = 0;
    while (!cpu_address_ready && waits < 200) begin
      @(negedge clock); #1; waits++;
    end
    @(negedge clock);
    cpu_request = 1'b0; cpu_write = 1'b0;
    #1;
    ack = cpu_data_ready;
  endtask

  task automatic do_load(input logic [31:0] a, output int stall, output logic pop_before,
                         output logic req_next, output int resp_lat, output logic [31:0] data);
    int cyc;
    int mdr_cyc;
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = 1'b0; cpu_size = 2'd2;
    cpu_address = a; cpu_write_data = 32'h0; cpu_write_strobe = 4'h0;
    #1;
    stall = 0; pop_before = 1'b0;
    while (!cpu_address_ready && stall < 200) begin
      pop_before = memory_data_ready;
      @(negedge clock); #1; stall++;
    end
    @(negedge clock);
    cpu_request = 1'b0;
    #1;
    req_next = memory_request;
    cyc = 0; mdr_cyc = -100;
    while (!cpu_data_ready && cyc < 200) begin
      if (memory_data_ready) mdr_cyc = cyc;
      @(negedge clock); #1; cyc++;
    end
    resp_lat = cyc - mdr_cyc;
    data = cpu_read_data;
  endtask

  task automatic wait_empty(output int cycles, output logic prev_mdr);
    cycles = 0; prev_mdr = 1'b0;
    while (!buffer_empty && cycles < 500) begin
      prev_mdr = memory_data_ready;
      @(negedge clock); #1; cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++; if (buffer_empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", buffer_empty); else passed++;
    checks++;
    if ({memory_request, memory_write, memory_size, memory_address, memory_write_data, memory_write_strobe} !== 72'h0)
      $display("FAIL reset_mem_out: got req=%0b addr=%h want all 0", memory_request, memory_address);
    else passed++;
    checks++;
    if ({cpu_read_data, cpu_address_ready, cpu_data_ready} !== 34'h0)
      $display("FAIL reset_cpu_out: got rdata=%h ar=%0b dr=%0b want 0", cpu_read_data, cpu_address_ready, cpu_data_ready);
    else passed++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_store_drain();
    int w1, w2, cyc;
    logic a1, a2, prev;
    slave_lat = 3; slave_hold = 1'b0; clear_log();
    cpu_store(32'h100, 32'h1111_1111, w1, a1);
    checks++; if (a1 !== 1'b1 || w1 != 0) $display("FAIL t1_ack_a: got ack=%0b waits=%0d want 1/0", a1, w1); else passed++;
    checks++; if (buffer_empty !== 1'b0) $display("FAIL t1_not_empty: got %0b want 0", buffer_empty); else passed++;
    cpu_store(32'h104, 32'h2222_2222, w2, a2);
    checks++; if (a2 !== 1'b1 || w2 != 0) $display("FAIL t1_ack_b: got ack=%0b waits=%0d want 1/0", a2, w2); else passed++;
    wait_empty(cyc, prev);
    checks++; if (buffer_empty !== 1'b1 || prev !== 1'b1) $display("FAIL t1_empty_after_b: got empty=%0b prev_dr=%0b want 1/1", buffer_empty, prev); else passed++;
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h100 || log_addr[1] !== 32'h104 ||
        log_data[0] !== 32'h1111_1111 || log_data[1] !== 32'h2222_2222)
      $display("FAIL t1_order: got %0d drains want A=0x100 then B=0x104", log_addr.size());
    else passed++;
  endtask

  task automatic test_full();
    int w, wsum, n, cyc;
    logic ack, acks, seen, prev, ok;
    slave_lat = 0; slave_hold = 1'b1; clear_log();
    wsum = 0; acks = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_store(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), w, ack);
      wsum += w; acks &= ack;
    end
    checks++; if (wsum != 0 || acks !== 1'b1) $display("FAIL t2_fill: got waits=%0d acks=%0b want 0/1", wsum, acks); else passed++;
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = 1'b1; cpu_address = 32'h20; cpu_write_data = 32'hA4;
    #1;
    checks++; if (cpu_address_ready !== 1'b0) $display("FAIL t2_full_blocks: got %0b want 0", cpu_address_ready); else passed++;
    seen = 1'b0;
    repeat (3) begin @(negedge clock); #1; if (cpu_address_ready) seen = 1'b1; end
    checks++; if (seen !== 1'b0) $display("FAIL t2_full_holds: got %0b want 0", seen); else passed++;
    slave_hold = 1'b0;
    n = 0;
    while (!memory_data_ready && n < 50) begin @(negedge clock); #1; n++; end
    checks++; if (memory_data_ready !== 1'b1 || cpu_address_ready !== 1'b0)
      $display("FAIL t2_pop_cycle: got dr=%0b ar=%0b want 1/0", memory_data_ready, cpu_address_ready);
    else passed++;
    @(negedge clock); #1;
    checks++; if (cpu_address_ready !== 1'b1) $display("FAIL t2_accept_after_pop: got %0b want 1", cpu_address_ready); else passed++;
    @(negedge clock);
    cpu_request = 1'b0; cpu_write = 1'b0;
    #1;
    checks++; if (cpu_data_ready !== 1'b1) $display("FAIL t2_fifth_ack: got %0b want 1", cpu_data_ready); else passed++;
    wait_empty(cyc, prev);
    ok = (log_addr.size() == 5);
    for (int i = 0; i < 5; i++) begin
      if (i >= log_addr.size() || log_addr[i] !== 32'h10 + 32'(4 * i) || log_write[i] !== 1'b1) ok = 1'b0;
    end
    checks++; if (ok !== 1'b1) $display("FAIL t2_drain_order: got %0d drains want 5 in order", log_addr.size()); else passed++;
  endtask

  task automatic test_load_hazard();
    int w, stall, rlat;
    logic ack, popb, reqn;
    logic [31:0] data;
    slave_lat = 0; slave_hold = 1'b0; slave_rdata = 32'hCAFE_F00D; clear_log();
    cpu_store(32'h200, 32'hDEAD_BEEF, w, ack);
    do_load(32'h202, stall, popb, reqn, rlat, data);
    checks++; if (stall < 1) $display("FAIL t3_stall: got %0d want >=1", stall); else passed++;
    checks++; if (popb !== 1'b1) $display("FAIL t3_accept_after_pop: got %0b want 1", popb); else passed++;
    checks++; if (reqn !== 1'b1) $display("FAIL t3_req_next: got %0b want 1", reqn); else passed++;
    checks++; if (rlat != 1) $display("FAIL t3_resp_lat: got %0d want 1", rlat); else passed++;
    checks++; if (data !== 32'hCAFE_F00D) $display("FAIL t3_data: got %h want cafef00d", data); else passed++;
    checks++;
    if (log_addr.size() != 2 || log_write[0] !== 1'b1 || log_write[1] !== 1'b0 ||
        log_addr[0] !== 32'h200 || log_data[0] !== 32'hDEAD_BEEF || log_addr[1] !== 32'h202)
      $display("FAIL t3_mem_order: got %0d txns want store 0x200 then load 0x202", log_addr.size());
    else passed++;
  endtask

  task automatic test_load_priority();
    int w, stall, rlat, cyc;
    logic ack, popb, reqn, prev;
    logic [31:0] data;
    slave_lat = 6; slave_hold = 1'b0; slave_rdata = 32'h0BAD_C0DE; clear_log();
    cpu_store(32'h500, 32'h5555_5555, w, ack);
    cpu_store(32'h300, 32'h3333_3333, w, ack);
    do_load(32'h400, stall, popb, reqn, rlat, data);
    checks++; if (stall != 0) $display("FAIL t4_no_stall: got %0d want 0", stall); else passed++;
    checks++; if (data !== 32'h0BAD_C0DE) $display("FAIL t4_data: got %h want 0badc0de", data); else passed++;
    wait_empty(cyc, prev);
    checks++;
    if (log_addr.size() != 3 || log_write[0] !== 1'b1 || log_addr[0] !== 32'h500 ||
        log_write[1] !== 1'b0 || log_addr[1] !== 32'h400 ||
        log_write[2] !== 1'b1 || log_addr[2] !== 32'h300 || log_data[2] !== 32'h3333_3333)
      $display("FAIL t4_order: got %0d txns want 0x500 W, 0x400 R, 0x300 W", log_addr.size());
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    int w, n, reqs;
    logic ack;
    slave_lat = 0; slave_hold = 1'b1; clear_log();
    cpu_store(32'h600, 32'h6, w, ack);
    cpu_store(32'h604, 32'h7, w, ack);
    cpu_store(32'h608, 32'h8, w, ack);
    slave_hold = 1'b0;
    n = 0;
    while (!memory_data_ready && n < 50) begin @(negedge clock); #1; n++; end
    checks++; if (memory_data_ready !== 1'b1) $display("FAIL t5_store_data: got %0b want 1", memory_data_ready); else passed++;
    reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if ({memory_request, memory_write, memory_size, memory_address, memory_write_data, memory_write_strobe} !== 72'h0 ||
        {cpu_read_data, cpu_address_ready, cpu_data_ready} !== 34'h0)
      $display("FAIL t5_outputs_zero: got req=%0b addr=%h rdata=%h want 0", memory_request, memory_address, cpu_read_data);
    else passed++;
    checks++; if (buffer_empty !== 1'b1) $display("FAIL t5_empty: got %0b want 1", buffer_empty); else passed++;
    reset = 1'b0;
    reqs = 0;
    repeat (10) begin @(negedge clock); #1; if (memory_request) reqs++; end
    checks++; if (reqs != 0 || log_addr.size() != 1) $display("FAIL t5_no_more_req: got reqs=%0d txns=%0d want 0/1", reqs, log_addr.size()); else passed++;
  endtask

  task automatic test_store_in_ack();
    int cyc;
    logic prev;
    slave_lat = 0; slave_hold = 1'b0; clear_log();
    @(negedge clock);
    cpu_request = 1'b1; cpu_write = 1'b1; cpu_size = 2'd2;
    cpu_address = 32'h700; cpu_write_data = 32'h77; cpu_write_strobe = 4'hf;
    #1;
    checks++; if (cpu_address_ready !== 1'b1) $display("FAIL t6_first_ready: got %0b want 1", cpu_address_ready); else passed++;
    @(negedge clock);
    cpu_address = 32'h704; cpu_write_data = 32'h78;
    #1;
    checks++; if (cpu_address_ready !== 1'b0 || cpu_data_ready !== 1'b1)
      $display("FAIL t6_ack_cycle: got ar=%0b dr=%0b want 0/1", cpu_address_ready, cpu_data_ready);
    else passed++;
    @(negedge clock); #1;
    checks++; if (cpu_address_ready !== 1'b1) $display("FAIL t6_next_idle: got %0b want 1", cpu_address_ready); else passed++;
    @(negedge clock);
    cpu_request = 1'b0; cpu_write = 1'b0;
    #1;
    checks++; if (cpu_data_ready !== 1'b1) $display("FAIL t6_second_ack: got %0b want 1", cpu_data_ready); else passed++;
    wait_empty(cyc, prev);
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h700 || log_addr[1] !== 32'h704 || log_data[1] !== 32'h78)
      $display("FAIL t6_drain: got %0d drains want 0x700 then 0x704", log_addr.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_full();
    test_load_hazard();
    test_load_priority();
    test_reset_mid_drain();
    test_store_in_ack();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
